// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the single register-file write port, with a registered
// write stage, starvation guard for requester 1 and a pending-destination scoreboard.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb0_valid,
  input  logic [ADDR_WIDTH-1:0]        wb0_addr,
  input  logic [DATA_WIDTH-1:0]        wb0_data,
  output logic                         wb0_ready,
  input  logic                         wb1_valid,
  input  logic [ADDR_WIDTH-1:0]        wb1_addr,
  input  logic [DATA_WIDTH-1:0]        wb1_data,
  output logic                         wb1_ready,
  input  logic                         issue_valid,
  input  logic [ADDR_WIDTH-1:0]        issue_addr,
  output logic                         RegWrite,
  output logic [ADDR_WIDTH-1:0]        WriteRegister,
  output logic [DATA_WIDTH-1:0]        WriteData,
  output logic [(2**ADDR_WIDTH)-1:0]   pending,
  output logic [3:0]                   starve_cnt
);

  localparam int         NREGS     = 2**ADDR_WIDTH;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [3:0] CNT_MAX   = 4'd15;

  logic                  r_regwrite;
  logic [ADDR_WIDTH-1:0] r_wreg;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NREGS-1:0]      r_pending;
  logic [3:0]            r_starve_cnt;

  logic                  w_force1;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [3:0]            w_starve_nxt;
  logic [NREGS-1:0]      w_set_mask;
  logic [NREGS-1:0]      w_clr_mask;
  logic [NREGS-1:0]      w_pending_nxt;

  // Grant: requester 0 wins unless requester 1 has waited STARVE_LIMIT cycles.
  always_comb begin
    w_force1 = (r_starve_cnt >= LIMIT);
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (reset) begin
      w_grant0 = wb0_valid & ~(w_force1 & wb1_valid);
      w_grant1 = wb1_valid & (~wb0_valid | w_force1);
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
    w_xfer = w_grant0 | w_grant1;
  end

  // Select the granted requester's address and data.
  always_comb begin
    w_sel_addr = wb0_addr;
    w_sel_data = wb0_data;
    if (w_grant1) begin
      w_sel_addr = wb1_addr;
      w_sel_data = wb1_data;
    end else begin
      w_sel_addr = wb0_addr;
      w_sel_data = wb0_data;
    end
  end

  // Starvation counter: runs only while requester 1 waits, saturating.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_grant1 || !wb1_valid) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve_cnt != CNT_MAX) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end else begin
      w_starve_nxt = r_starve_cnt;
    end
  end

  // Scoreboard: a new issue outranks a completing write to the same index.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (issue_valid && (issue_addr != '0)) begin
      w_set_mask[issue_addr] = 1'b1;
    end else begin
      w_set_mask = '0;
    end
    if (w_grant1 && (wb1_addr != '0)) begin
      w_clr_mask[wb1_addr] = 1'b1;
    end else begin
      w_clr_mask = '0;
    end
    w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
    w_pending_nxt[0] = 1'b0;
  end

  // Registered write stage, scoreboard and counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regwrite   <= 1'b0;
      r_wreg       <= '0;
      r_wdata      <= '0;
      r_pending    <= '0;
      r_starve_cnt <= 4'd0;
    end else begin
      r_regwrite   <= w_xfer && (w_sel_addr != '0);
      if (w_xfer) begin
        r_wreg  <= w_sel_addr;
        r_wdata <= w_sel_data;
      end else begin
        r_wreg  <= r_wreg;
        r_wdata <= r_wdata;
      end
      r_pending    <= w_pending_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  assign wb0_ready     = w_grant0;
  assign wb1_ready     = w_grant1;
  assign RegWrite      = r_regwrite;
  assign WriteRegister = r_wreg;
  assign WriteData     = r_wdata;
  assign pending       = r_pending;
  assign starve_cnt    = r_starve_cnt;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (RegWrite / WriteRegister / WriteData) between two requesters.
  - Requester 0: the main pipeline writeback.
  - Requester 1: a multi-cycle unit (multiplier/divider, load unit).
- Uses valid/ready handshakes, fixed priority with anti-starvation, and one registered output stage.
- Keeps a pending-destination scoreboard for in-flight multi-cycle results, so hazard logic can stall readers of those registers.
- Sits between the writeback stages and the register file.

Parameters:
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers).
- STARVE_LIMIT, 3, consecutive lost cycles after which requester 1 gets forced priority (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb0_valid  in  1  requester 0 has a write.
- wb0_addr  in  ADDR_WIDTH  requester 0 destination.
- wb0_data  in  DATA_WIDTH  requester 0 data.
- wb0_ready  out  1  requester 0 write accepted this cycle.
- wb1_valid  in  1  requester 1 has a write.
- wb1_addr  in  ADDR_WIDTH  requester 1 destination.
- wb1_data  in  DATA_WIDTH  requester 1 data.
- wb1_ready  out  1  requester 1 write accepted this cycle.
- issue_valid  in  1  a multi-cycle op was issued; mark its destination pending.
- issue_addr  in  ADDR_WIDTH  destination of the issued op.
- RegWrite  out  1  register file write enable.
- WriteRegister  out  ADDR_WIDTH  register file write index.
- WriteData  out  DATA_WIDTH  register file write data.
- pending  out  2**ADDR_WIDTH  bit i = 1: register i awaits a requester-1 result.
- starve_cnt  out  4  current starvation count (debug).

Behaviour:
- Reset (reset=0, asynchronous):
  - RegWrite=0, WriteRegister=0, WriteData=0, pending=0, starve_cnt=0.
  - wb0_ready=0 and wb1_ready=0 while reset is asserted.
  - Reset mid-transfer discards any registered write; nothing is replayed.
- Grant (combinational, at most one per cycle):
  - force1 = (starve_cnt >= STARVE_LIMIT).
  - wb0_ready = wb0_valid & ~(force1 & wb1_valid).
  - wb1_ready = wb1_valid & (~wb0_valid | force1).
- Handshake: transfer happens when valid & ready.
  - Requesters hold valid, addr and data stable until accepted; the arbiter never drops an accepted write.
- Output stage, latency 1. On the clock edge after a transfer:
  - RegWrite=1; WriteRegister and WriteData take the granted addr/data.
  - With no transfer, RegWrite=0 and WriteRegister/WriteData hold their last values.
  - Back-to-back transfers give a write every cycle.
- Register 0:
  - A transfer to addr 0 is accepted (ready=1) but produces RegWrite=0 the next cycle.
  - issue_valid with addr 0 never sets pending[0]; pending[0] is constant 0.
- starve_cnt, each cycle:
  - Cleared to 0 when wb1 transfers or when wb1_valid=0.
  - Incremented when wb1_valid=1 and wb1_ready=0.
  - Saturates at 15.
- pending scoreboard, per bit i, priority in this order:
  - Set when issue_valid & issue_addr==i (i≠0).
  - Else cleared on the edge where wb1 transfers with wb1_addr==i.
  - Else held.
  - Set and clear of the same index in one cycle: stays 1, because the newer op wins.
  - Issue to an already-pending index: stays 1.
  - A wb1 transfer to a non-pending index is legal and leaves pending unchanged.
- pending clears on the same edge the write is registered. RegWrite appears that cycle and the register file captures the data on the following edge. Consumers that need the value treat RegWrite & WriteRegister==i as still busy.
- wb0 transfers never touch pending or starve_cnt.

Test Plan:
- Reset release, no requests → all outputs 0 for 5 cycles; then wb0_valid=1, addr=5, data=0xDEADBEEF → wb0_ready=1 same cycle; next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; following cycle RegWrite=0.
- Both valid every cycle with STARVE_LIMIT=3 → wb0 granted 3 cycles while starve_cnt goes 0,1,2,3; 4th cycle wb1 granted and starve_cnt returns to 0; pattern repeats 3:1.
- issue_valid addr=9, later wb1 write addr=9 data=0x12345678 → pending[9]=1 from the edge after issue; clears on the transfer edge; RegWrite=1, WriteRegister=9 that cycle.
- Same cycle: issue_valid addr=7 and wb1 transfer addr=7 (pending[7]=1) → pending[7] stays 1; write still issued with WriteRegister=7.
- wb0 write addr=0 data=0xFFFFFFFF, and issue_valid addr=0 → ready=1, RegWrite stays 0, pending[0] stays 0.
- Assert reset low mid-cycle while a granted write is registered (RegWrite=1) and pending=0x00000200 → RegWrite, pending and starve_cnt go to 0 immediately, without waiting for a clock; the write does not reappear after release.
